counter_checker: RTL

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker_pkg.sv | 12 +
 rtl/counter_checker_fifo.sv | 53 +++++
 rtl/counter_checker.sv | 112 +++++++++++
 3 files changed

// File: rtl/counter_checker_pkg.sv
// Shared types and constants for the counter_checker block.
package counter_checker_pkg;

  localparam int ERR_COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/counter_checker_fifo.sv
// Sample FIFO: registered storage, latency-1 visibility, push accepted when full if a pop frees a slot.
module counter_checker_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (level == '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/counter_checker.sv
// Monitors an upstream counter for +1 steps and samples it into a FIFO every SAMPLE_DIV cycles.
// Optional macro COUNTER_CHECKER_ERR_CAPTURE_EN enables capture of the first mismatching value.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 8,
  parameter int SAMPLE_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       cnt_in,
  input  logic                   cnt_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   err_step,
  output logic [ERR_COUNT_W-1:0] err_count,
  output logic                   overflow,
  output logic [WIDTH-1:0]       err_value
);

  localparam int DIV_W = $clog2(SAMPLE_DIV) + 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic [DIV_W-1:0] divider;
  logic             mismatch;
  logic             sample_push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    state_next = state;
    if (!cnt_valid) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_ARM;
        ST_ARM:   state_next = ST_CHECK;
        ST_CHECK: state_next = ST_CHECK;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Only CHECK compares; IDLE and ARM just refresh the baseline so a restart never flags.
  assign mismatch = cnt_valid && (state == ST_CHECK) && (cnt_in != WIDTH'(prev + 1'b1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev      <= '0;
      err_step  <= 1'b0;
      err_count <= '0;
    end else begin
      if (cnt_valid) prev <= cnt_in;
      if (mismatch) begin
        err_step <= 1'b1;
        if (err_count != {ERR_COUNT_W{1'b1}}) err_count <= err_count + 1'b1;
      end
    end
  end

  assign sample_push = cnt_valid && (divider == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || !cnt_valid) divider <= '0;
    else if (sample_push)       divider <= '0;
    else                        divider <= divider + 1'b1;
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  counter_checker_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (sample_push),
    .push_data (cnt_in),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)                                 overflow <= 1'b0;
    else if (sample_push && fifo_full && !pop)    overflow <= 1'b1;
  end

`ifdef COUNTER_CHECKER_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                  err_value <= '0;
    else if (mismatch && !err_step) err_value <= cnt_in;
  end
`else
  assign err_value = '0;
`endif

endmodule
